instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch_skid_buffer.sv | 36 +++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU fetch definitions: fetch FSM state encoding, NOP word, address helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/ack bus between the fetch stage and instruction memory.
// Latency: ack may come in the request cycle (zero-wait) or any later cycle.
// Backpressure: the requester holds req and addr stable until ack.
interface instruction_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry holding slot for a fetched word that arrives while IF/ID is stalled.
// Latency: load visible the cycle after the load edge; unload frees the slot in one edge.
// Backpressure: the owner must not load while full; flush wins over load and unload.
module fetch_skid_buffer
    import instruction_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        flush,
    input  logic [31:0] load_pc_4,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc_4,
    output logic [31:0] instr
);

    // Slot occupancy and payload; flush discards, load captures, unload empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            pc_4  <= 32'h0000_0000;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc_4  <= load_pc_4;
            instr <= load_instr;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives instruction memory from pc and feeds the IF/ID register.
// Latency: one cycle from memory ack to if_valid; one instruction per cycle at zero wait.
// Backpressure: stall freezes outputs, one word parks in the skid slot, then req drops.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    instruction_fetch_if.master        imem,
    output logic [31:0]                if_pc_4,
    output logic [31:0]                if_instruction,
    output logic                       if_valid
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  discard_addr;
    logic [31:0]  pc_plus_4;
    logic [31:0]  redirect_target;
    logic         req;
    logic         accept;
    logic         deliver;
    logic         pend_valid;
    logic [31:0]  pend_pc_4;
    logic [31:0]  pend_instr;

    // While discarding, the abandoned request keeps its original address until it acks.
    assign req             = ((state == ST_FETCH) && !pend_valid) || (state == ST_DISCARD);
    assign imem.imem_req   = req;
    assign imem.imem_addr  = (state == ST_DISCARD) ? discard_addr : pc;
    assign pc_plus_4       = pc + 32'd4;
    assign redirect_target = word_align(redirect_pc);
    assign accept          = (state == ST_FETCH) && req && imem.imem_ack;
    assign deliver         = accept && !redirect;

    // Fetch FSM and program counter; redirect retargets pc in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            discard_addr <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    if (redirect) begin
                        pc <= redirect_target;
                    end
                end
                ST_FETCH: begin
                    if (redirect) begin
                        pc <= redirect_target;
                        // An unacked request cannot be withdrawn; wait it out.
                        if (req && !imem.imem_ack) begin
                            state        <= ST_DISCARD;
                            discard_addr <= pc;
                        end
                    end else if (accept) begin
                        pc <= pc_plus_4;
                    end
                end
                ST_DISCARD: begin
                    if (redirect) begin
                        pc <= redirect_target;
                    end
                    if (imem.imem_ack) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // IF/ID feed: redirect bubbles, stall holds, otherwise new word, parked word or bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            if_valid       <= 1'b0;
            if_pc_4        <= 32'h0000_0000;
            if_instruction <= NOP_INSTR;
        end else if (redirect) begin
            if_valid       <= 1'b0;
            if_pc_4        <= 32'h0000_0000;
            if_instruction <= NOP_INSTR;
        end else if (!stall) begin
            if (deliver) begin
                if_valid       <= 1'b1;
                if_pc_4        <= pc_plus_4;
                if_instruction <= imem.imem_rdata;
            end else if (pend_valid) begin
                if_valid       <= 1'b1;
                if_pc_4        <= pend_pc_4;
                if_instruction <= pend_instr;
            end else begin
                if_valid       <= 1'b0;
                if_pc_4        <= 32'h0000_0000;
                if_instruction <= NOP_INSTR;
            end
        end
    end

    fetch_skid_buffer u_skid (
        .clock      (clock),
        .reset      (reset),
        .load       (deliver && stall),
        .unload     (!redirect && !stall && pend_valid),
        .flush      (redirect),
        .load_pc_4  (pc_plus_4),
        .load_instr (imem.imem_rdata),
        .valid      (pend_valid),
        .pc_4       (pend_pc_4),
        .instr      (pend_instr)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: zero-wait and 2-cycle memory, stall, redirect, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: memory model acks immediately or on the third request cycle.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        lat_mode;
    logic        extra_ack;
    logic [1:0]  wcnt;

    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic        if_valid;

    logic        hi_stall       = 1'b0;
    logic        hi_redirect    = 1'b0;
    logic [31:0] hi_redirect_pc = 32'h0000_0000;
    logic [31:0] hi_pc_4;
    logic [31:0] hi_instruction;
    logic        hi_valid;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instruction_fetch_if m_if ();
    instruction_fetch_if h_if ();

    // Memory for the main DUT: data = address; ack at once or on third request cycle.
    always_ff @(posedge clock) begin
        if (reset || !m_if.imem_req || m_if.imem_ack) wcnt <= 2'd0;
        else                                          wcnt <= wcnt + 2'd1;
    end
    assign m_if.imem_ack   = (m_if.imem_req && (!lat_mode || wcnt == 2'd2)) || extra_ack;
    assign m_if.imem_rdata = m_if.imem_addr;

    assign h_if.imem_ack   = h_if.imem_req;
    assign h_if.imem_rdata = h_if.imem_addr;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (m_if),
        .if_pc_4        (if_pc_4),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clock          (clock),
        .reset          (reset),
        .stall          (hi_stall),
        .redirect       (hi_redirect),
        .redirect_pc    (hi_redirect_pc),
        .imem           (h_if),
        .if_pc_4        (hi_pc_4),
        .if_instruction (hi_instruction),
        .if_valid       (hi_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] p4,
                             input logic [31:0] ins);
        check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        check({tag, ".pc_4"}, if_pc_4, p4);
        check({tag, ".instr"}, if_instruction, ins);
    endtask

    task automatic check_bus(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, {31'd0, m_if.imem_req}, {31'd0, r});
        check({tag, ".addr"}, m_if.imem_addr, a);
    endtask

    initial begin
        // Reset with stall/redirect/ack all asserted: reset must win.
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0123;
        lat_mode = 1'b0; extra_ack = 1'b1;
        tick(); tick();
        check_out("rst", 1'b0, 32'h0, 32'h0);
        check_bus("rst", 1'b0, 32'h0);
        check("rst_hi.addr", h_if.imem_addr, 32'hFFFF_FFFC);
        check("rst_hi.req", {31'd0, h_if.imem_req}, 32'd0);

        // IDLE cycle: stray ack still present, no request.
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        check_bus("idle", 1'b0, 32'h0);
        tick();
        extra_ack = 1'b0;
        check_out("fetch0", 1'b0, 32'h0, 32'h0);
        check_bus("fetch0", 1'b1, 32'h0);
        check("hi_fetch0.addr", h_if.imem_addr, 32'hFFFF_FFFC);

        // Zero-wait streaming: one instruction per cycle.
        tick();
        check_out("zw0", 1'b1, 32'h4, 32'h0);
        check("hi_first.pc_4", hi_pc_4, 32'h0);
        check("hi_first.instr", hi_instruction, 32'hFFFF_FFFC);
        check("hi_second.addr", h_if.imem_addr, 32'h0);
        tick();
        check_out("zw1", 1'b1, 32'h8, 32'h4);
        check("hi_next.pc_4", hi_pc_4, 32'h4);
        check("hi_next.instr", hi_instruction, 32'h0);
        tick();
        check_out("zw2", 1'b1, 32'hC, 32'h8);
        tick();
        check_out("zw3", 1'b1, 32'h10, 32'hC);
        tick();
        check_out("zw4", 1'b1, 32'h14, 32'h10);
        check_bus("zw4", 1'b1, 32'h14);

        // Stall three cycles while the 0x10 entry is on the outputs.
        stall = 1'b1;
        tick();
        check_out("stall1", 1'b1, 32'h14, 32'h10);
        check_bus("stall1", 1'b0, 32'h18);
        tick();
        check_out("stall2", 1'b1, 32'h14, 32'h10);
        check_bus("stall2", 1'b0, 32'h18);
        tick();
        check_out("stall3", 1'b1, 32'h14, 32'h10);
        stall = 1'b0;
        check_bus("unload", 1'b0, 32'h18);
        tick();
        check_out("release", 1'b1, 32'h18, 32'h14);
        check_bus("release", 1'b1, 32'h18);
        tick();
        check_out("resume", 1'b1, 32'h1C, 32'h18);

        // Redirect coinciding with ack under stall: word at 0x1C dropped.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0041;
        tick();
        stall = 1'b0; redirect = 1'b0;
        check_out("redir_ack", 1'b0, 32'h0, 32'h0);
        check_bus("redir_ack", 1'b1, 32'h40);
        tick();
        check_out("redir_tgt", 1'b1, 32'h44, 32'h40);

        // Two-cycle-latency memory from a fresh reset.
        reset = 1'b1; lat_mode = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_out("lat_e1", 1'b0, 32'h0, 32'h0);
        check_bus("lat_e1", 1'b1, 32'h0);
        tick();
        check_bus("lat_e2", 1'b1, 32'h0);
        check("lat_e2.valid", {31'd0, if_valid}, 32'd0);
        tick();
        check_bus("lat_e3", 1'b1, 32'h0);
        check("lat_e3.valid", {31'd0, if_valid}, 32'd0);
        tick();
        check_out("lat_e4", 1'b1, 32'h4, 32'h0);
        check_bus("lat_e4", 1'b1, 32'h4);
        tick();
        check_out("lat_e5", 1'b0, 32'h0, 32'h0);
        tick();
        check_bus("lat_e6", 1'b1, 32'h4);
        tick();
        check_out("lat_e7", 1'b1, 32'h8, 32'h4);

        // Run to the first cycle of the request to 0x20, bounded.
        for (int n = 0; n < 40 && m_if.imem_addr != 32'h20; n++) tick();
        check("reach_0x20.addr", m_if.imem_addr, 32'h20);
        check_out("at_0x20", 1'b1, 32'h20, 32'h1C);

        // Redirect while 0x20 is outstanding: discard it, refetch at 0x200.
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        check_out("disc1", 1'b0, 32'h0, 32'h0);
        check_bus("disc1", 1'b1, 32'h20);
        tick();
        check_out("disc2", 1'b0, 32'h0, 32'h0);
        check_bus("disc2", 1'b1, 32'h20);
        tick();
        check_out("disc_end", 1'b0, 32'h0, 32'h0);
        check_bus("disc_end", 1'b1, 32'h200);
        tick();
        check_out("tgt_w1", 1'b0, 32'h0, 32'h0);
        tick();
        check_out("tgt_w2", 1'b0, 32'h0, 32'h0);
        tick();
        check_out("tgt_data", 1'b1, 32'h204, 32'h200);
        check_bus("tgt_next", 1'b1, 32'h204);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
